// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: reset PC default, fetch FSM states and queue entry layout.
package mips_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc+4} entries with a synchronous flush used on redirect.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output logic         empty_o,
    output logic         full_o,
    output fetch_entry_t head_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_en, pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rptr_q];

    // A flush wins over any push or pop presented in the same cycle.
    assign pop_en  = pop_i && !empty_o && !clear_i;
    assign push_en = push_i && (!full_o || pop_en) && !clear_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop_en) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push_en) begin
                mem_q[wptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: owns the fetch PC, issues req/ack fetches into a prefetch queue, handles redirects.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ack,
    input  logic [31:0] im_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc_plus4,
    input  logic        inst_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    logic         fifo_push;
    logic         fifo_empty;
    logic         fifo_full;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A request stays up until acked: count only falls while it waits, so !full cannot drop.
    assign im_req  = !Reset && ((state_q == DROP) || !fifo_full);
    assign im_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;

    assign push_entry.instr    = im_data;
    assign push_entry.pc_plus4 = im_addr + 32'd4;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        fifo_push   = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            if (im_req && !im_ack) begin
                state_d     = DROP;
                drop_addr_d = im_addr;
            end else begin
                state_d = FETCH;
            end
        end else if (im_req && im_ack) begin
            if (state_q == DROP) begin
                state_d = FETCH;
            end else begin
                fifo_push  = 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= FETCH;
            fetch_pc_q  <= {RESET_PC[31:2], 2'b00};
            drop_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .Clk         (Clk),
        .Reset       (Reset),
        .clear_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (inst_valid && inst_ready),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .head_o      (fifo_head)
    );

    assign inst_valid    = !fifo_empty;
    assign inst          = fifo_head.instr;
    assign inst_pc_plus4 = fifo_head.pc_plus4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed plus randomized bench for ifetch_queue against a queue-based reference model.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk;
    logic        Reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc_plus4;
    logic        inst_ready;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_req         (im_req),
        .im_addr        (im_addr),
        .im_ack         (im_ack),
        .im_data        (im_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc_plus4  (inst_pc_plus4),
        .inst_ready     (inst_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: buffered entries, architectural fetch PC, and a pending stale transaction.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic        m_drop;
    logic [31:0] m_drop_addr;
    logic        m_zero_head;
    logic        m_live;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic rdv, input logic [31:0] rpc,
                        input logic ack_want, input logic [31:0] data, input logic data_is_addr,
                        input logic rdy);
        logic        req_e;
        logic [31:0] addr_e;
        logic        ack;
        logic [31:0] d;
        @(negedge Clk);
        req_e  = !rst && (m_drop || m_q.size() < int'(DEPTH));
        addr_e = m_drop ? m_drop_addr : m_pc;
        ack    = ack_want && req_e;
        d      = data_is_addr ? addr_e : data;
        Reset          = rst;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        im_ack         = ack;
        im_data        = d;
        inst_ready     = rdy;
        #1;
        if (m_live) begin
            check_eq("im_req", {31'd0, im_req}, {31'd0, req_e});
            check_eq("im_addr", im_addr, addr_e);
            check_eq("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                check_eq("inst", inst, m_q[0][63:32]);
                check_eq("inst_pc_plus4", inst_pc_plus4, m_q[0][31:0]);
            end else if (m_zero_head) begin
                check_eq("inst_rst", inst, 32'd0);
                check_eq("pc4_rst", inst_pc_plus4, 32'd0);
            end
        end
        @(posedge Clk);
        if (rst) begin
            m_q.delete();
            m_pc        = RESET_PC;
            m_drop      = 1'b0;
            m_zero_head = 1'b1;
            m_live      = 1'b1;
        end else if (m_live) begin
            if (rdv) begin
                m_drop_addr = (req_e && !ack) ? addr_e : m_drop_addr;
                m_drop      = req_e && !ack;
                m_q.delete();
                m_pc        = rpc & 32'hFFFF_FFFC;
            end else begin
                if (m_q.size() > 0 && rdy) begin
                    void'(m_q.pop_front());
                end
                if (ack) begin
                    if (m_drop) begin
                        m_drop = 1'b0;
                    end else begin
                        m_q.push_back({d, addr_e + 32'd4});
                        m_pc        = m_pc + 32'd4;
                        m_zero_head = 1'b0;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rpc;
        n_vec          = 0;
        n_err          = 0;
        m_live         = 1'b0;
        m_drop         = 1'b0;
        m_drop_addr    = '0;
        m_pc           = RESET_PC;
        m_zero_head    = 1'b1;
        Reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        im_ack         = 1'b0;
        im_data        = '0;
        inst_ready     = 1'b0;

        tick(1, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0);

        // Streaming: ack every cycle, data equals address.
        for (int i = 0; i < 12; i++) tick(0, 0, 0, 1, 0, 1, 1);
        // Stall decode until the queue fills, then drain.
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1, 0, 1, 1);

        // Redirect with a request outstanding; stale ack three cycles later.
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 1, 32'h0000_0040, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0, 1, 1);

        // Redirect coinciding with an ack.
        tick(0, 1, 32'h0000_0100, 1, 32'hBAD0_BAD0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 1, 1);

        // Unaligned redirect target.
        tick(0, 1, 32'h0000_0043, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 1, 1);
        tick(0, 0, 0, 1, 0, 1, 1);

        // Address wrap at the top of memory.
        tick(0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0, 1);

        // Reset in the middle of a drop without ever acking.
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 1, 32'h0000_0200, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            tick($urandom_range(199) == 0, $urandom_range(15) == 0, rpc,
                 $urandom_range(2) != 0, $urandom, 1'b0, $urandom_range(3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch unit with a small prefetch queue, sitting directly upstream of the IF/ID pipeline register. It owns the fetch PC and fetches from a variable-latency instruction memory over a req/ack handshake. It buffers up to DEPTH instructions and hands them to the decode stage under a valid/ready handshake. Branch and jump redirects from ID flush the queue and restart fetch at the new target.

## Interface
- DEPTH, 4: queue entries; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- Clk  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- im_req  out  1  memory request.
- im_addr  out  32  word-aligned fetch address; stable while im_req=1 and im_ack=0.
- im_ack  in  1  completes the current transaction in the same cycle; im_data valid in that cycle.
- im_data  in  32  fetched instruction word.
- inst_valid  out  1  queue head valid.
- inst  out  32  head instruction.
- inst_pc_plus4  out  32  head address + 4, for the IF/ID PC field.
- inst_ready  in  1  decode accepts head; low means ID is stalled.

## Operation
- Reset values: im_req=0, im_addr=RESET_PC, inst_valid=0, inst=0, inst_pc_plus4=0, count=0, state=FETCH.
- Each entry holds {instr, pc+4}. A pop happens when inst_valid && inst_ready.
- Slot reservation: a request issues only while count + outstanding < DEPTH, with at most one outstanding request.
- States:
  - FETCH: im_req=1 when the reservation condition holds. On im_ack:
    - push im_data with im_addr+4;
    - fetch_pc += 4, wrapping 0xFFFF_FFFC -> 0.
  - DROP: im_req=1 and im_addr held at the stale address until im_ack. The acked data is discarded, then go to FETCH.
- Redirect, registered in the cycle redirect_valid=1:
  - Queue cleared; no pop occurs that cycle, whatever inst_ready is.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - If a request is outstanding without ack that cycle, go to DROP and hold the new PC pending.
  - If im_ack arrives in the same cycle as the redirect, discard that data; the next cycle requests the redirect target.
  - A redirect while in DROP overwrites the pending PC and stays in DROP.
- Push and pop in the same cycle are both allowed when non-empty; count is unchanged.
- Full: im_req=0 until a pop frees a slot.
- Reset has priority over everything. Reset during DROP aborts without waiting for ack. The memory tolerates an abandoned request.

## Timing
- First request is in the cycle after Reset deasserts.
- Latency: im_ack in cycle N with an empty queue gives inst_valid=1 in cycle N+1 (registered queue output).
- Back-to-back fetches: im_req stays high across an ack. The next transaction, at addr+4, starts in cycle N+1.
- Redirect in cycle R, with no outstanding request or an ack in R:
  - im_addr=target in R+1;
  - inst_valid=0 in R+1 at the earliest.
- Redirect in cycle R with an outstanding request: stale ack at cycle A ≥ R+1, then target request at A+1.
- inst_valid falls in the cycle after the last pop; no combinational path from im_ack to inst_valid.
- inst_ready may depend combinationally on inst/inst_valid; im_req must not depend on inst_ready in the same cycle.

## Structure
- Shared package mips_pkg: RESET_PC default constant, fetch state enum {FETCH, DROP}, and the instruction width constant.
- One sub-module, fetch_fifo: a synchronous FIFO of {instr, pc+4}, DEPTH entries, with a synchronous clear input used for redirect.
- The top handles the fetch FSM, PC register, reservation counter and handshake.

## Test plan
- Reset, then im_ack every cycle with im_data = address, inst_ready=1:
  - im_addr sequence 0,4,8,...;
  - inst=0 and inst_pc_plus4=4 one cycle after the first ack;
  - one instruction per cycle thereafter.
- inst_ready=0 with immediate acks:
  - exactly DEPTH=4 acks accepted, then im_req=0;
  - raising inst_ready drains 0,4,8,12 in order, and im_req reasserts after the first pop.
- Redirect to 0x40 while a request to 0x8 is outstanding, ack 3 cycles later:
  - im_addr stays 0x8 until the ack, and its data never appears;
  - next request is 0x40, and the first delivered inst_pc_plus4=0x44.
- Redirect with im_ack in the same cycle: acked data dropped, queue empty, im_addr=target the next cycle.
- Redirect to 0x43: im_addr=0x40.
- Fetch from 0xFFFF_FFFC: next im_addr=0, with inst_pc_plus4=0 for that entry.
- Reset asserted mid-DROP with no ack: all outputs return to reset values next cycle, and the first request after release is to RESET_PC.
